// File: rtl/symbol_slicer_mer.sv
// Four-level (4-ASK) decision slicer with a windowed mean-squared-error estimator.
// Pipeline: S1 slice, S2 error/saturate, S3 square, ACC window accumulate.
module symbol_slicer_mer #(
    parameter int WIN_LOG2 = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic [17:0] dec_var,
    input  logic [17:0] ref_level,
    output logic [1:0]  sym_out,
    output logic        sym_valid,
    output logic [17:0] slice_err,
    output logic [17:0] err_power,
    output logic        err_valid
);

    localparam int ACC_W = 18 + WIN_LOG2;
    localparam logic signed [19:0] E_MAX = 20'sd131071;
    localparam logic signed [19:0] E_MIN = -20'sd131072;

    // Valid semantics: sym_valid is a level that stays high once the first
    // decision is live and only matters on clk_en cycles; err_valid is a
    // single-clk pulse, there is no ready/backpressure on either output.

    // ---------------------------------------------------------------
    // S1: thresholds and ideal levels
    // ---------------------------------------------------------------
    logic signed [17:0] x_in;
    logic signed [17:0] a_in;
    logic signed [17:0] a_half;
    logic signed [18:0] x19;
    logic signed [18:0] a19;
    logic signed [18:0] neg_a;
    logic signed [18:0] lvl_inner;
    logic signed [18:0] lvl_outer;
    logic        [1:0]  sym_next;
    logic signed [18:0] lvl_next;

    assign x_in      = $signed(dec_var);
    assign a_in      = $signed(ref_level);
    assign a_half    = a_in >>> 1;
    assign x19       = {x_in[17], x_in};
    assign a19       = {a_in[17], a_in};
    assign neg_a     = -a19;
    assign lvl_inner = {a_half[17], a_half};
    assign lvl_outer = a19 + lvl_inner;

    // Ties resolve to the upper symbol, so every compare is >=.
    always_comb begin
        sym_next = 2'b00;
        lvl_next = -lvl_outer;
        if (x19 >= a19) begin
            sym_next = 2'b11;
            lvl_next = lvl_outer;
        end else if (x19 >= 19'sd0) begin
            sym_next = 2'b10;
            lvl_next = lvl_inner;
        end else if (x19 >= neg_a) begin
            sym_next = 2'b01;
            lvl_next = -lvl_inner;
        end
    end

    logic        [1:0]  sym_s1;
    logic signed [18:0] lvl_s1;
    logic signed [17:0] x_s1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_s1 <= 2'b00;
            lvl_s1 <= '0;
            x_s1   <= '0;
        end else if (clk_en) begin
            sym_s1 <= sym_next;
            lvl_s1 <= lvl_next;
            x_s1   <= x_in;
        end
    end

    // ---------------------------------------------------------------
    // S2: error at 20 bits, clamped to 18-bit signed
    // ---------------------------------------------------------------
    logic signed [19:0] e20;
    logic signed [17:0] err_sat;
    logic signed [17:0] err_s2;

    assign e20 = {{2{x_s1[17]}}, x_s1} - {lvl_s1[18], lvl_s1};

    always_comb begin
        err_sat = e20[17:0];
        if (e20 > E_MAX) begin
            err_sat = 18'sh1FFFF;
        end else if (e20 < E_MIN) begin
            err_sat = 18'sh20000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_s2 <= '0;
        end else if (clk_en) begin
            err_s2 <= err_sat;
        end
    end

    // ---------------------------------------------------------------
    // S3: squared error, rescaled back to 1s17 by dropping 17 LSBs
    // ---------------------------------------------------------------
    logic signed [35:0] prod;
    logic        [17:0] sq_next;
    logic        [17:0] sq_s3;

    assign prod    = err_s2 * err_s2;
    assign sq_next = 18'(prod >>> 17);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq_s3 <= '0;
        end else if (clk_en) begin
            sq_s3 <= sq_next;
        end
    end

    // ---------------------------------------------------------------
    // Pipeline fill tracking: keeps reset bubbles out of the window
    // ---------------------------------------------------------------
    logic [2:0] vld;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld <= 3'b000;
        end else if (clk_en) begin
            vld <= {vld[1:0], 1'b1};
        end
    end

    // ---------------------------------------------------------------
    // ACC: window accumulation; the closing sample is folded into the
    // published mean but not carried into the next window
    // ---------------------------------------------------------------
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_sum;
    logic [WIN_LOG2-1:0] win_cnt;
    logic                acc_en;
    logic                window_close;
    logic [17:0]         power_next;

    assign acc_en       = clk_en & vld[2];
    assign acc_sum      = acc + {{WIN_LOG2{1'b0}}, sq_s3};
    assign window_close = acc_en & (win_cnt == '1);
    assign power_next   = 18'(acc_sum >> WIN_LOG2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc       <= '0;
            win_cnt   <= '0;
            err_power <= '0;
            err_valid <= 1'b0;
        end else begin
            err_valid <= window_close;
            if (acc_en) begin
                win_cnt <= win_cnt + 1'b1;
                if (window_close) begin
                    acc       <= '0;
                    err_power <= power_next;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

    assign sym_out   = sym_s1;
    assign sym_valid = vld[0];
    assign slice_err = err_s2;

endmodule

// File: tb/tb_symbol_slicer_mer.sv
// Self-checking bench for symbol_slicer_mer: constant vector table, window,
// clk_en gap and mid-window reset sequences, then randomized traffic.
module tb_symbol_slicer_mer;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic [17:0] dec_var;
    logic [17:0] ref_level;
    logic [1:0]  sym_out;
    logic        sym_valid;
    logic [17:0] slice_err;
    logic [17:0] err_power;
    logic        err_valid;

    symbol_slicer_mer #(.WIN_LOG2(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .dec_var   (dec_var),
        .ref_level (ref_level),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .slice_err (slice_err),
        .err_power (err_power),
        .err_valid (err_valid)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [1:0]  exp_sym_q[$];
    logic [17:0] exp_err_q[$];
    int          fill_q[$];
    logic [1:0]  cur_sym;
    logic [17:0] cur_err;
    logic [17:0] exp_power;
    logic        exp_evalid;
    int          win_sum;
    int          win_n;
    int          edge_cnt;
    int          clk_cnt = 0;
    int          first_pulse_edge;
    int          last_pulse_clk;
    int          pulse_gap;
    int          pulse_cnt;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_sym_q.delete();
        exp_err_q.delete();
        fill_q.delete();
        exp_err_q.push_back(18'h0);
        for (int i = 0; i < 3; i++) fill_q.push_back(-1);
        cur_sym          = 2'b00;
        cur_err          = 18'h0;
        exp_power        = 18'h0;
        exp_evalid       = 1'b0;
        win_sum          = 0;
        win_n            = 0;
        edge_cnt         = 0;
        first_pulse_edge = -1;
        last_pulse_clk   = -1;
        pulse_gap        = -1;
        pulse_cnt        = 0;
    endtask

    // Reference: decision rule, error, squared error and window mean from plain arithmetic.
    task automatic model_sample(input logic [17:0] xv, input logic [17:0] av);
        int x, a, half, outer, lvl, err, sq, v;
        logic [1:0] sym;
        longint p;
        x     = int'($signed(xv));
        a     = int'($signed(av));
        half  = a >>> 1;
        outer = a + half;
        if (x >= a)            begin sym = 2'b11; lvl = outer;  end
        else if (x >= 0)       begin sym = 2'b10; lvl = half;   end
        else if (x >= -a)      begin sym = 2'b01; lvl = -half;  end
        else                   begin sym = 2'b00; lvl = -outer; end
        err = x - lvl;
        if (err > 131071)  err = 131071;
        if (err < -131072) err = -131072;
        p  = longint'(err) * longint'(err);
        sq = int'(p >> 17);
        exp_sym_q.push_back(sym);
        exp_err_q.push_back(18'(err));
        fill_q.push_back(sq);
        cur_sym    = exp_sym_q.pop_front();
        cur_err    = exp_err_q.pop_front();
        v          = fill_q.pop_front();
        exp_evalid = 1'b0;
        if (v >= 0) begin
            win_sum += v;
            win_n++;
            if (win_n == (1 << W)) begin
                exp_power  = 18'(win_sum / (1 << W));
                exp_evalid = 1'b1;
                win_sum    = 0;
                win_n      = 0;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic en, input logic [17:0] xv, input logic [17:0] av);
        clk_en    = en;
        dec_var   = xv;
        ref_level = av;
        @(posedge clk);
        #1;
        clk_cnt++;
        if (en) begin
            edge_cnt++;
            model_sample(xv, av);
        end else begin
            exp_evalid = 1'b0;
        end
        check("sym_out",   sym_out,   cur_sym);
        check("slice_err", slice_err, cur_err);
        check("sym_valid", sym_valid, edge_cnt >= 1);
        check("err_valid", err_valid, exp_evalid);
        check("err_power", err_power, exp_power);
        if (err_valid) begin
            if (first_pulse_edge < 0) first_pulse_edge = edge_cnt;
            if (last_pulse_clk >= 0) pulse_gap = clk_cnt - last_pulse_clk;
            last_pulse_clk = clk_cnt;
            pulse_cnt++;
        end
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_rst_sym"},   sym_out,   2'b00);
        check({tag, "_rst_err"},   slice_err, 18'h0);
        check({tag, "_rst_power"}, err_power, 18'h0);
        check({tag, "_rst_svld"},  sym_valid, 1'b0);
        check({tag, "_rst_evld"},  err_valid, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [17:0] x;
        logic [17:0] a;
        logic [1:0]  sym;
        logic [17:0] err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{18'h10000, 18'h08000, 2'b11, 18'h04000};
        vecs[1]  = '{18'h03333, 18'h08000, 2'b10, 18'h3F333};
        vecs[2]  = '{18'h3CCCD, 18'h08000, 2'b01, 18'h00CCD};
        vecs[3]  = '{18'h30000, 18'h08000, 2'b00, 18'h3C000};
        vecs[4]  = '{18'h08000, 18'h08000, 2'b11, 18'h3C000};
        vecs[5]  = '{18'h00000, 18'h08000, 2'b10, 18'h3C000};
        vecs[6]  = '{18'h38000, 18'h08000, 2'b01, 18'h3C000};
        vecs[7]  = '{18'h0C000, 18'h08000, 2'b11, 18'h00000};
        vecs[8]  = '{18'h20000, 18'h1FFFF, 2'b00, 18'h0FFFE};
        vecs[9]  = '{18'h1FFFF, 18'h1FFFF, 2'b11, 18'h30001};
        vecs[10] = '{18'h1FFFF, 18'h20000, 2'b11, 18'h1FFFF};
        vecs[11] = '{18'h20000, 18'h30000, 2'b00, 18'h20000};

        reset     = 1'b0;
        clk_en    = 1'b0;
        dec_var   = '0;
        ref_level = '0;
        model_reset();
        #12;
        apply_reset("init");

        // Slicing, ties and saturation
        for (int i = 0; i < 12; i++) begin
            step(1'b1, vecs[i].x, vecs[i].a);
            check("tbl_sym", sym_out, vecs[i].sym);
            if (i > 0) check("tbl_err", slice_err, vecs[i-1].err);
        end
        step(1'b1, vecs[11].x, vecs[11].a);
        check("tbl_err", slice_err, vecs[11].err);

        // Window: constant e = 0x4000 -> sq = 0x800
        apply_reset("win");
        for (int i = 0; i < 40; i++) step(1'b1, 18'h10000, 18'h08000);
        check("win_first_edge", first_pulse_edge, 19);
        check("win_pulses",     pulse_cnt,        2);
        check("win_gap",        pulse_gap,        16);
        check("win_power",      err_power,        18'h800);

        // Reset mid-window after 10 accumulated samples of the third window
        for (int i = 0; i < 5; i++) step(1'b1, 18'h10000, 18'h08000);
        apply_reset("mid");
        for (int i = 0; i < 24; i++) step(1'b1, 18'h10000, 18'h08000);
        check("mid_first_edge", first_pulse_edge, 19);
        check("mid_power",      err_power,        18'h800);

        // clk_en high 1 cycle in 3
        apply_reset("gap");
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 18'h10000, 18'h08000);
            step(1'b0, 18'h2AAAA, 18'h01234);
            step(1'b0, 18'h15555, 18'h04321);
        end
        check("gap_first_edge", first_pulse_edge, 19);
        check("gap_pulses",     pulse_cnt,        2);
        check("gap_spacing",    pulse_gap,        48);
        check("gap_power",      err_power,        18'h800);

        // Randomized traffic with ref_level changes on the fly
        apply_reset("rand");
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0,
                 18'($urandom_range(0, 'h3FFFF)),
                 18'($urandom_range(0, 'h1FFFF)));
        end
        check("rand_pulses_seen", pulse_cnt >= 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
